// File: rtl/spi_readback_tx_pkg.sv
// Shared definitions for the SPI readback transmitter and the MCU-side driver layout.
package spi_readback_tx_pkg;
  localparam int unsigned HDR_W         = 8;
  localparam int unsigned SEQ_W         = HDR_W - 1;
  localparam int unsigned WORD_W_DEF    = 16;
  localparam int unsigned NUM_WORDS_DEF = 4;
  localparam int unsigned FRAME_BITS    = HDR_W + NUM_WORDS_DEF * WORD_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVERRUN
  } state_e;
endpackage

// File: rtl/spi_edge_detect.sv
// Two-flop synchronizer plus previous-value register producing level and edge strobes
// for one asynchronous SPI pin.
module spi_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;

  // Edges stay masked until the pin has been observed at its idle level after reset,
  // so a line held active through reset never yields a spurious edge.
  always_comb begin
    meta_d  = din;
    sync_d  = meta_q;
    prev_d  = sync_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & (sync_q == RST_VAL));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q  <= RST_VAL;
      sync_q  <= RST_VAL;
      prev_q  <= RST_VAL;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign level = sync_q;
  assign rise  = armed_q & sync_q & ~prev_q;
  assign fall  = armed_q & ~sync_q & prev_q;
endmodule

// File: rtl/spi_readback_tx.sv
// SPI mode-0 peripheral transmitter returning {fresh, seq, shadow payload} frames on SDO,
// with SCK/CS oversampled in the system clock domain.
module spi_readback_tx
  import spi_readback_tx_pkg::*;
#(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sck,
  input  logic                        cs,
  output logic                        sdo,
  output logic                        sdo_en,
  input  logic [NUM_WORDS*WORD_W-1:0] frame_data,
  input  logic                        data_valid,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_abort
);
  localparam int unsigned PAY_W = NUM_WORDS * WORD_W;
  localparam int unsigned FRM_W = HDR_W + PAY_W;
  localparam int unsigned CNT_W = $clog2(FRM_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FRM_W);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic unused_sck_lvl, unused_cs_lvl;

  spi_edge_detect #(.RST_VAL(1'b0)) u_sck_edge (
    .clk(clk), .reset(reset), .din(sck),
    .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_edge_detect #(.RST_VAL(1'b1)) u_cs_edge (
    .clk(clk), .reset(reset), .din(cs),
    .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  state_e             state_q, state_d;
  logic [FRM_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAY_W-1:0]   shadow_q, shadow_d;
  logic               fresh_q, fresh_d;
  logic               upd_q, upd_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    fresh_d  = fresh_q;
    upd_d    = upd_q;
    seq_d    = seq_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;

    if (data_valid) begin
      shadow_d = frame_data;
      fresh_d  = 1'b1;
      upd_d    = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shift_d = {fresh_q, seq_q, shadow_q};
          cnt_d   = '0;
          upd_d   = data_valid;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == FULL) begin
            done_d  = 1'b1;
            seq_d   = seq_q + 1'b1;
            // Only data already sent is consumed; an update that landed mid-frame stays fresh.
            fresh_d = upd_q | data_valid;
          end else begin
            abort_d = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == FULL) state_d = OVERRUN;
          end
          if (sck_fall) shift_d = {shift_q[FRM_W-2:0], 1'b0};
        end
      end
      OVERRUN: begin
        if (cs_rise) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      fresh_q  <= 1'b0;
      upd_q    <= 1'b0;
      seq_q    <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      fresh_q  <= fresh_d;
      upd_q    <= upd_d;
      seq_q    <= seq_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign sdo_en      = (state_q != IDLE);
  assign sdo         = (state_q == SHIFT) & shift_q[FRM_W-1];
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
endmodule

// File: tb/tb_spi_readback_tx.sv
// Scoreboard bench: an MCU model clocks mode-0 frames; monitors compare SDO bits and
// done/abort pulses against a frame-level reference model.
module tb_spi_readback_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        data_valid = 1'b0;
  logic [63:0] frame_data = '0;
  logic        sdo, sdo_en, busy, frame_done, frame_abort;

  spi_readback_tx #(.WORD_W(16), .NUM_WORDS(4)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .sdo(sdo), .sdo_en(sdo_en),
    .frame_data(frame_data), .data_valid(data_valid), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // Reference model: producer-visible frame state
  bit        m_fresh = 1'b0;
  bit [6:0]  m_seq = '0;
  bit [63:0] m_shadow = '0;

  bit       exp_bits[$];
  bit [1:0] exp_evt[$];   // {done, abort}
  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_dv(logic [63:0] d);
    frame_data = d;
    data_valid = 1'b1;
    wait_clk(1);
    data_valid = 1'b0;
    m_shadow = d;
    m_fresh  = 1'b1;
  endtask

  task automatic push_frame(int nbits);
    logic [71:0] frm;
    frm = {m_fresh, m_seq, m_shadow};
    for (int i = 0; i < nbits; i++)
      exp_bits.push_back(i < 72 ? frm[71-i] : 1'b0);
  endtask

  task automatic shift_bits(int n, int dv_at, logic [63:0] dv_data);
    for (int i = 1; i <= n; i++) begin
      sck = 1'b1;
      if (i == dv_at) begin
        pulse_dv(dv_data);
        wait_clk(7);
      end else begin
        wait_clk(8);
      end
      sck = 1'b0;
      wait_clk(8);
    end
  endtask

  task automatic run_frame(int nbits, int dv_at, logic [63:0] dv_data);
    push_frame(nbits);
    cs = 1'b0;
    wait_clk(8);
    check("busy_in_frame", {sdo_en, busy}, 2'b11);
    shift_bits(nbits, dv_at, dv_data);
    wait_clk(4);
    cs = 1'b1;
    if (nbits == 72) begin
      exp_evt.push_back(2'b10);
      m_seq   = m_seq + 7'd1;
      m_fresh = (dv_at != 0);
    end else begin
      exp_evt.push_back(2'b01);
    end
    wait_clk(12);
    check("pulse_pending", exp_evt.size(), 0);
    check("bits_left", exp_bits.size(), 0);
    check("idle_outputs", {sdo, sdo_en, busy}, 3'b000);
  endtask

  // SDO monitor: the MCU samples on each rising SCK while selected
  always @(posedge sck) begin
    if (!cs) begin
      if (exp_bits.size() == 0) begin
        check("sdo_extra_bit", 1'b1, 1'b0);
      end else begin
        check("sdo_bit", sdo, exp_bits.pop_front());
        check("sdo_en_active", sdo_en, 1'b1);
      end
    end
  end

  // Pulse monitor
  always @(posedge clk) begin
    #1;
    if (frame_done || frame_abort) begin
      if (exp_evt.size() == 0) check("pulse_unexpected", {frame_done, frame_abort}, 2'b00);
      else                     check("pulse_kind", {frame_done, frame_abort}, exp_evt.pop_front());
    end
  end

  initial begin
    int n, r, dv_at;
    reset = 1'b0;
    wait_clk(3);
    check("reset_outputs", {sdo, sdo_en, busy, frame_done, frame_abort}, 5'b0);
    wait_clk(2);
    reset = 1'b1;
    wait_clk(10);

    // basic, stale reread, mid-frame update, then the updated frame
    pulse_dv(64'h1234_5678_9ABC_DEF0);
    wait_clk(4);
    run_frame(72, 0, '0);
    run_frame(72, 0, '0);
    run_frame(72, 20, 64'hFFFF_FFFF_FFFF_FFFF);
    run_frame(72, 0, '0);

    // early release and overrun leave seq/fresh untouched
    pulse_dv(64'hA5A5_0F0F_3C3C_9696);
    wait_clk(4);
    run_frame(30, 0, '0);
    run_frame(80, 0, '0);
    run_frame(72, 0, '0);

    // reset mid-frame with CS held low
    push_frame(72);
    cs = 1'b0;
    wait_clk(8);
    shift_bits(40, 0, '0);
    reset = 1'b0;
    wait_clk(3);
    check("in_reset_outputs", {sdo, sdo_en, busy, frame_done, frame_abort}, 5'b0);
    wait_clk(2);
    reset = 1'b1;
    exp_bits.delete();
    m_fresh = 1'b0;
    m_seq = '0;
    m_shadow = '0;
    wait_clk(12);
    check("post_reset_quiet", {sdo, sdo_en, busy}, 3'b000);
    cs = 1'b1;
    wait_clk(10);
    run_frame(72, 0, '0);

    // randomized frames
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 2);
      n = (r == 0) ? 72 : (r == 1) ? $urandom_range(1, 71) : $urandom_range(73, 80);
      if ($urandom_range(0, 1) == 1) begin
        pulse_dv({$urandom, $urandom});
        wait_clk(3);
      end
      dv_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      run_frame(n, dv_at, {$urandom, $urandom});
    end

    wait_clk(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
